// File: rtl/fft_pkg.sv
// Shared FFT32 sequencing constants: transform size, SDF stage delays,
// stage offset/latency arithmetic and output index bit reversal.
package fft_pkg;
    localparam int N       = 32;
    localparam int N_STAGE = 5;
    // Stage k delay lives in bits [5k+4:5k]: 16, 8, 4, 2, 1.
    localparam logic [24:0] STG_DLY = {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

    function automatic int stage_offset(input int k, input int stg_lat);
        int s;
        s = k * stg_lat;
        for (int j = 0; j < k; j++) s += int'(STG_DLY[5*j +: 5]);
        return s;
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = x[4-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_stage_cnt.sv
// Local sample counter for one SDF stage; produces the fill/butterfly mode
// and the twiddle exponent once the stage has been primed.
module fft_stage_cnt
    import fft_pkg::*;
#(
    parameter int K       = 0,
    parameter int STG_LAT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_adv,
    input  logic       i_load,
    input  logic       i_prime_upd,
    input  logic [5:0] i_ecnt_nxt,
    output logic       o_mode,
    output logic [3:0] o_tw
);
    localparam int         OFF      = stage_offset(K, STG_LAT);
    localparam logic [4:0] CNT_LOAD = 5'((N - (OFF % N)) % N);
    localparam logic [5:0] OFF_W    = 6'(OFF);
    localparam logic [3:0] TW_MASK  = 4'(int'(STG_DLY[5*K +: 5]) - 1);

    logic [4:0] r_cnt;
    logic       r_primed;
    logic       w_mode;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else begin
            if (i_load)
                r_cnt <= CNT_LOAD;
            else if (i_adv)
                r_cnt <= r_cnt + 5'd1;
            if (i_prime_upd)
                r_primed <= (i_ecnt_nxt >= OFF_W);
        end
    end

    assign w_mode = r_primed & r_cnt[4-K];
    assign o_mode = w_mode;
    assign o_tw   = (r_primed & ~w_mode) ? ((r_cnt[3:0] & TW_MASK) << K) : 4'd0;
endmodule

// File: rtl/fft32_seq_ctrl.sv
// 32-point radix-2 SDF sequencing controller: stage modes, twiddles, output framing.
// Define FFT_SEQ_BITREV_EN to present out_idx_o in bit-reversed (native DIF) order.
module fft32_seq_ctrl
    import fft_pkg::*;
#(
    parameter int STG_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        sof_i,
    output logic        en_o,
    output logic [4:0]  stg_mode_o,
    output logic [19:0] stg_tw_o,
    output logic        valid_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic [4:0]  out_idx_o,
    output logic [7:0]  frame_cnt_o,
    output logic        sync_err_o
);
    localparam int         LAT   = stage_offset(N_STAGE, STG_LAT);
    localparam logic [5:0] LAT_W = 6'(LAT);
    localparam logic [4:0] LAT_G = 5'(LAT % N);

    logic       r_en;
    logic       r_started;
    logic       r_sync_err;
    logic [4:0] r_g;
    logic [5:0] r_ecnt;
    logic [7:0] r_frames;
    logic       w_load;
    logic       w_start;
    logic       w_prime_upd;
    logic       w_valid;
    logic [5:0] w_ecnt_nxt;
    logic [4:0] w_raw;

    assign w_load      = valid_i & sof_i;
    // A sof restarts the sequence unless it lands exactly on the frame boundary.
    assign w_start     = w_load & (~r_started | (r_g != 5'd31));
    assign w_prime_upd = valid_i & (r_started | w_start);

    always_comb begin
        w_ecnt_nxt = r_ecnt;
        if (w_start)
            w_ecnt_nxt = '0;
        else if (valid_i && r_started && (r_ecnt < LAT_W))
            w_ecnt_nxt = r_ecnt + 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_started  <= 1'b0;
            r_sync_err <= 1'b0;
            r_g        <= '0;
            r_ecnt     <= '0;
            r_frames   <= '0;
        end else begin
            r_en       <= valid_i;
            r_sync_err <= w_start & r_started;
            r_started  <= r_started | w_start;
            r_ecnt     <= w_ecnt_nxt;
            if (w_load)
                r_g <= '0;
            else if (valid_i)
                r_g <= r_g + 5'd1;
            if (eof_o)
                r_frames <= r_frames + 8'd1;
        end
    end

    for (genvar k = 0; k < N_STAGE; k++) begin : g_stage
        fft_stage_cnt #(.K(k), .STG_LAT(STG_LAT)) u_stage (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_adv       (valid_i),
            .i_load      (w_load),
            .i_prime_upd (w_prime_upd),
            .i_ecnt_nxt  (w_ecnt_nxt),
            .o_mode      (stg_mode_o[k]),
            .o_tw        (stg_tw_o[4*k +: 4])
        );
    end

    assign w_valid     = r_en & (r_ecnt >= LAT_W);
    assign w_raw       = r_g - LAT_G;
    assign en_o        = r_en;
    assign valid_o     = w_valid;
    assign sof_o       = w_valid & (w_raw == 5'd0);
    assign eof_o       = w_valid & (w_raw == 5'd31);
    assign frame_cnt_o = r_frames;
    assign sync_err_o  = r_sync_err;
`ifdef FFT_SEQ_BITREV_EN
    assign out_idx_o   = w_valid ? bitrev5(w_raw) : 5'd0;
`else
    assign out_idx_o   = w_valid ? w_raw : 5'd0;
`endif
endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// Bench for fft32_seq_ctrl: directed scenarios and random traffic scored
// against a sample-level reference model through an expectation queue.
`timescale 1ns/1ps
module tb_fft32_seq_ctrl;
    import fft_pkg::*;

    localparam int STG_LAT = 1;
    localparam int LAT     = 31 + 5 * STG_LAT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        sof_i = 1'b0;
    logic        en_o;
    logic [4:0]  stg_mode_o;
    logic [19:0] stg_tw_o;
    logic        valid_o, sof_o, eof_o;
    logic [4:0]  out_idx_o;
    logic [7:0]  frame_cnt_o;
    logic        sync_err_o;

    fft32_seq_ctrl #(.STG_LAT(STG_LAT)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sof_i(sof_i),
        .en_o(en_o), .stg_mode_o(stg_mode_o), .stg_tw_o(stg_tw_o),
        .valid_o(valid_o), .sof_o(sof_o), .eof_o(eof_o),
        .out_idx_o(out_idx_o), .frame_cnt_o(frame_cnt_o), .sync_err_o(sync_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  mode;
        logic [19:0] tw;
        logic        vld;
        logic        sof;
        logic        eof;
        logic        sync;
        logic [4:0]  idx;
        logic [7:0]  frames;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   off[5];
    int   m_started, m_g, m_n, m_frames;
    int   tr_sofi, tr_sofo, tr_eofo, tr_sync;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: n = samples since the (re)starting sof, g = index within the frame.
    task automatic model_step(input bit s);
        exp_t e;
        int   c, raw;
        bit   sync;
        sync = 1'b0;
        if (s && (m_started == 0 || m_g != 31)) begin
            sync = (m_started != 0);
            m_started = 1;
            m_n = 0;
            m_g = 0;
        end else begin
            m_g = (m_g + 1) % 32;
            if (m_started != 0) m_n++;
        end
        e = '0;
        for (int k = 0; k < 5; k++) begin
            if (m_started != 0 && m_n >= off[k]) begin
                c = (m_g - off[k] + 64) % 32;
                e.mode[k] = ((c >> (4 - k)) & 1) == 1;
                if (!e.mode[k]) e.tw[4*k +: 4] = 4'((c % (16 >> k)) << k);
            end
        end
        e.vld = (m_started != 0) && (m_n >= LAT);
        raw   = (m_g - (LAT % 32) + 32) % 32;
        e.sof = e.vld && raw == 0;
        e.eof = e.vld && raw == 31;
        if (e.vld) begin
`ifdef FFT_SEQ_BITREV_EN
            e.idx = bitrev5(5'(raw));
`else
            e.idx = 5'(raw);
`endif
        end
        e.sync   = sync;
        e.frames = 8'(m_frames);
        if (e.eof) m_frames++;
        q.push_back(e);
    endtask

    task automatic drive(input bit v, input bit s);
        @(posedge clk);
        #1;
        valid_i = v;
        sof_i   = s;
        if (v && s && tr_sofi < 0) tr_sofi = cyc;
        if (v) model_step(s);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, m_started == 0 || m_g == 31);
    endtask

    task automatic arm();
        tr_sofi = -1; tr_sofo = -1; tr_eofo = -1; tr_sync = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        rst     = 1'b1;
        q.delete();
        m_started = 0; m_g = 0; m_n = 0; m_frames = 0;
        #1;
        chk("rst_async_ctl", {en_o, valid_o, sof_o, eof_o, sync_err_o, stg_mode_o, stg_tw_o}, 0);
        chk("rst_async_cnt", {frame_cnt_o, out_idx_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per enabled cycle, checks holds in gaps.
    initial begin
        exp_t e;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_hold", {en_o, valid_o, sync_err_o, stg_mode_o, stg_tw_o, frame_cnt_o}, 0);
                last = '0;
            end else if (en_o) begin
                chk("sb_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("valid_o", valid_o, e.vld);
                    chk("stg_mode_o", stg_mode_o, e.mode);
                    chk("stg_tw_o", stg_tw_o, e.tw);
                    chk("sync_err_o", sync_err_o, e.sync);
                    chk("frame_cnt_o", frame_cnt_o, e.frames);
                    if (e.vld) begin
                        chk("sof_o", sof_o, e.sof);
                        chk("eof_o", eof_o, e.eof);
                        chk("out_idx_o", out_idx_o, e.idx);
                    end
                    last = e;
                    last.frames = e.frames + 8'(e.eof);
                end
                if (valid_o && sof_o && tr_sofo < 0) tr_sofo = cyc;
                if (valid_o && eof_o && tr_eofo < 0) tr_eofo = cyc;
                if (sync_err_o) tr_sync++;
            end else begin
                chk("gap_flags", {valid_o, sof_o, eof_o, sync_err_o}, 0);
                chk("gap_mode_hold", stg_mode_o, last.mode);
                chk("gap_tw_hold", stg_tw_o, last.tw);
                chk("gap_frames", frame_cnt_o, last.frames);
            end
        end
    end

    initial begin
        bit v, s;
        for (int k = 0; k < 5; k++) begin
            off[k] = k * STG_LAT;
            for (int j = 0; j < k; j++) off[k] += 16 >> j;
        end
        arm();

        // Contiguous frames: first output latency, frame length, frame count.
        do_reset();
        arm();
        run(96);
        repeat (3) drive(1'b0, 1'b0);
        chk("lat_first_sof_o", tr_sofo - tr_sofi, LAT + 1);
        chk("eof_after_sof_o", tr_eofo - tr_sofo, 31);
        chk("frame_cnt_one", frame_cnt_o, 1);

        // Ten-cycle input gap at g=20 stretches latency by ten.
        do_reset();
        arm();
        run(21);
        repeat (10) drive(1'b0, 1'($urandom_range(0, 1)));
        run(60);
        repeat (3) drive(1'b0, 1'b0);
        chk("lat_with_gap", tr_sofo - tr_sofi, LAT + 11);

        // Mid-frame sof at g=12: one sync pulse and a full restart.
        do_reset();
        arm();
        run(12);
        tr_sofi = -1;
        tr_sofo = -1;
        drive(1'b1, 1'b1);
        run(45);
        repeat (3) drive(1'b0, 1'b0);
        chk("sync_pulses", tr_sync, 1);
        chk("lat_after_resync", tr_sofo - tr_sofi, LAT + 1);

        // Reset at g=25 of the second frame, then stray samples before the new sof.
        do_reset();
        run(58);
        do_reset();
        arm();
        repeat (5) drive(1'b1, 1'b0);
        run(50);
        repeat (3) drive(1'b0, 1'b0);
        chk("lat_after_reset", tr_sofo - tr_sofi, LAT + 1);

        // Random traffic: gaps, ignored sof, boundary sofs, occasional resync/reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 99) < 85);
            if (v) begin
                if (m_started == 0)
                    s = ($urandom_range(0, 7) == 0);
                else if (m_g == 31)
                    s = ($urandom_range(0, 19) != 0);
                else
                    s = ($urandom_range(0, 99) == 0);
            end else begin
                s = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 999) == 0)
                do_reset();
            else
                drive(v, s);
        end
        repeat (5) drive(1'b0, 1'b0);
        chk("sb_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
